// File: rtl/exit_decider.sv
// Early-exit controller: runs network stages in order, samples the argmax result after
// each one, and stops at the first stage whose winning score clears the threshold.
module exit_decider #(
  parameter int featureWidth = 16,
  parameter int NUM_STAGES   = 3,
  parameter int TIMEOUT      = 31
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           sample_start,
  input  logic signed [featureWidth-1:0] threshold,
  output logic                           stage_go,
  output logic        [1:0]              stage_sel,
  input  logic                           stage_done,
  output logic                           max_enable,
  input  logic        [2:0]              maxindex,
  input  logic signed [featureWidth-1:0] max,
  input  logic                           outvalid,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic        [2:0]              result_class,
  output logic signed [featureWidth-1:0] result_score,
  output logic        [1:0]              result_stage,
  output logic                           result_early,
  output logic                           result_err,
  output logic                           busy,
  output logic        [2:0]              dbg_state
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COMPUTE = 3'd1,
    S_ARGMAX  = 3'd2,
    S_DECIDE  = 3'd3,
    S_RESULT  = 3'd4
  } state_t;

  state_t                         state;
  logic signed [featureWidth-1:0] thr_q;
  logic signed [featureWidth-1:0] cap_score;
  logic        [2:0]              cap_class;
  logic        [WD_W-1:0]         wd;
  logic                           last_stage;

  assign last_stage = (stage_sel == 2'(NUM_STAGES - 1));
  assign dbg_state  = state;

  // Result handshake: the decision is transferred on a cycle where result_valid && result_ready;
  // while result_valid && !result_ready every result_* field holds its value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      stage_go     <= 1'b0;
      stage_sel    <= 2'd0;
      max_enable   <= 1'b0;
      result_valid <= 1'b0;
      result_class <= 3'd0;
      result_score <= '0;
      result_stage <= 2'd0;
      result_early <= 1'b0;
      result_err   <= 1'b0;
      busy         <= 1'b0;
      thr_q        <= '0;
      cap_score    <= '0;
      cap_class    <= 3'd0;
      wd           <= '0;
    end else begin
      stage_go <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sample_start) begin
            thr_q     <= threshold;
            stage_sel <= 2'd0;
            stage_go  <= 1'b1;
            busy      <= 1'b1;
            state     <= S_COMPUTE;
          end
        end
        S_COMPUTE: begin
          // Enable stays low here so the argmax block is cleared between stages.
          if (stage_done) begin
            max_enable <= 1'b1;
            wd         <= '0;
            state      <= S_ARGMAX;
          end
        end
        S_ARGMAX: begin
          if (outvalid) begin
            cap_class  <= maxindex;
            cap_score  <= max;
            max_enable <= 1'b0;
            state      <= S_DECIDE;
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            max_enable   <= 1'b0;
            result_valid <= 1'b1;
            result_err   <= 1'b1;
            result_class <= 3'd0;
            result_score <= '0;
            result_stage <= stage_sel;
            result_early <= 1'b0;
            state        <= S_RESULT;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        S_DECIDE: begin
          if ((cap_score >= thr_q) || last_stage) begin
            result_valid <= 1'b1;
            result_err   <= 1'b0;
            result_class <= cap_class;
            result_score <= cap_score;
            result_stage <= stage_sel;
            result_early <= !last_stage;
            state        <= S_RESULT;
          end else begin
            stage_sel <= stage_sel + 2'd1;
            stage_go  <= 1'b1;
            state     <= S_COMPUTE;
          end
        end
        S_RESULT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: begin
          max_enable   <= 1'b0;
          result_valid <= 1'b0;
          busy         <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule
